// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state encodings and sizing helpers for product_accumulator
package mult_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ACCUM = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    // Ceiling log2, used to size the product counter (clog2(1) = 0).
    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int x = v - 1; x > 0; x = x >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Default accumulator width: product width plus two guard bits.
    function automatic int default_acc_w(input int width);
        return 2 * width + 2;
    endfunction

endpackage

// File: rtl/product_accumulator_sat_adder.sv
// rtl/product_accumulator_sat_adder.sv - sat_adder: a+b with optional saturation (PRODUCT_ACCUMULATOR_SAT_EN)
module sat_adder #(
    parameter int ACC_W = 10
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

`ifdef PRODUCT_ACCUMULATOR_SAT_EN
    // Carry out of the top accumulator bit clamps the result to all ones.
    logic [ACC_W:0] full;
    assign full = {1'b0, a} + {1'b0, b};
    assign sum  = full[ACC_W] ? {ACC_W{1'b1}} : full[ACC_W-1:0];
    assign ovf  = full[ACC_W];
`else
    // Plain modulo-2^ACC_W addition; overflow is never reported.
    assign sum = a + b;
    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/product_accumulator.sv
// rtl/product_accumulator.sv - sums COUNT products per result over valid/ready (saturation via PRODUCT_ACCUMULATOR_SAT_EN)
module product_accumulator
    import mult_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int COUNT = 4,
    parameter int ACC_W = default_acc_w(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2*WIDTH-1:0] in_product,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_sum,
    output logic               out_ovf
);

    localparam int CNT_W = clog2(COUNT + 1);

    logic [1:0]       state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             out_valid_q, out_valid_d;

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;

    assign prod_ext = ACC_W'(in_product);

    sat_adder #(.ACC_W(ACC_W)) u_sat_adder (
        .a   (acc_q),
        .b   (prod_ext),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    // Product intake is blocked only while a finished result waits for its consumer.
    assign in_ready  = (state_q != ST_DONE);
    assign out_valid = out_valid_q;
    assign out_sum   = acc_q;
    assign out_ovf   = ovf_q;

    // Next-state: clear overrides everything, otherwise accept products or hand off the result.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = out_valid_q;
        if (clear) begin
            state_d     = ST_IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        acc_d = prod_ext;
                        cnt_d = CNT_W'(1);
                        ovf_d = 1'b0;
                        if (COUNT == 1) begin
                            state_d     = ST_DONE;
                            out_valid_d = 1'b1;
                        end else begin
                            state_d = ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (in_valid) begin
                        acc_d = add_sum;
                        ovf_d = ovf_q | add_ovf;
                        cnt_d = cnt_q + CNT_W'(1);
                        if (cnt_q == CNT_W'(COUNT - 1)) begin
                            state_d     = ST_DONE;
                            out_valid_d = 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d     = ST_IDLE;
                        cnt_d       = '0;
                        ovf_d       = 1'b0;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    out_valid_d = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// tb/tb_product_accumulator.sv - directed self-checking bench for product_accumulator
module tb_product_accumulator;

    logic       clk;
    logic       rst_n;

    logic       clear, in_valid, in_ready, out_valid, out_ready, out_ovf;
    logic [7:0] in_product;
    logic [9:0] out_sum;

    logic       clear9, in_valid9, in_ready9, out_valid9, out_ready9, out_ovf9;
    logic [7:0] in_product9;
    logic [8:0] out_sum9;

    logic       clear1, in_valid1, in_ready1, out_valid1, out_ready1, out_ovf1;
    logic [7:0] in_product1;
    logic [9:0] out_sum1;

    int vectors;
    int miscompares;

    product_accumulator #(.WIDTH(4), .COUNT(4), .ACC_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_product(in_product), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_ovf(out_ovf)
    );

    product_accumulator #(.WIDTH(4), .COUNT(4), .ACC_W(9)) dut9 (
        .clk(clk), .rst_n(rst_n), .clear(clear9), .in_valid(in_valid9), .in_ready(in_ready9),
        .in_product(in_product9), .out_valid(out_valid9), .out_ready(out_ready9),
        .out_sum(out_sum9), .out_ovf(out_ovf9)
    );

    product_accumulator #(.WIDTH(4), .COUNT(1), .ACC_W(10)) dut1 (
        .clk(clk), .rst_n(rst_n), .clear(clear1), .in_valid(in_valid1), .in_ready(in_ready1),
        .in_product(in_product1), .out_valid(out_valid1), .out_ready(out_ready1),
        .out_sum(out_sum1), .out_ovf(out_ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] p);
        in_valid   = 1'b1;
        in_product = p;
        tick();
        in_valid   = 1'b0;
        in_product = 8'hxx;
    endtask

    task automatic push9(input logic [7:0] p);
        in_valid9   = 1'b1;
        in_product9 = p;
        tick();
        in_valid9   = 1'b0;
    endtask

    initial begin
        int gap;
        int hold;
        logic [7:0] p;
        logic [31:0] exp9_sum;
        logic [31:0] exp9_ovf;

        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0;
        clear = 0; in_valid = 0; out_ready = 0; in_product = 0;
        clear9 = 0; in_valid9 = 0; out_ready9 = 0; in_product9 = 0;
        clear1 = 0; in_valid1 = 0; out_ready1 = 0; in_product1 = 0;
        @(negedge clk);
        tick();
        tick();
        rst_n = 1'b1;

        // 1: reset state and basic stream
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_sum", out_sum, 0);
        chk("rst_out_ovf", out_ovf, 0);
        chk("rst_in_ready", in_ready, 1);
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_product = 15;  tick();
        chk("t1_no_early_valid", out_valid, 0);
        in_product = 5;   tick();
        in_product = 165; tick();
        in_product = 225; tick();
        in_valid = 1'b0;
        chk("t1_out_valid", out_valid, 1);
        chk("t1_out_sum", out_sum, 410);
        chk("t1_out_ovf", out_ovf, 0);
        chk("t1_in_ready_done", in_ready, 0);
        tick();
        chk("t1_valid_drop", out_valid, 0);
        chk("t1_in_ready_back", in_ready, 1);

        // 2: back-pressure holds the result
        out_ready = 1'b0;
        push(15); push(5); push(165); push(225);
        in_valid = 1'b1;
        in_product = 99;
        for (int i = 0; i < 3; i++) begin
            chk("t2_hold_valid", out_valid, 1);
            chk("t2_hold_sum", out_sum, 410);
            chk("t2_hold_in_ready", in_ready, 0);
            tick();
        end
        in_valid = 1'b0;
        chk("t2_still_sum", out_sum, 410);
        out_ready = 1'b1;
        tick();
        chk("t2_valid_drop", out_valid, 0);
        chk("t2_idle_in_ready", in_ready, 1);
        push(1); push(2); push(3); push(4);
        chk("t2_second_valid", out_valid, 1);
        chk("t2_second_sum", out_sum, 10);
        tick();

        // 3: clear aborts and blocks a same-cycle product
        push(100); push(100);
        clear = 1'b1;
        in_valid = 1'b1;
        in_product = 50;
        chk("t3_in_ready_clear", in_ready, 1);
        tick();
        clear = 1'b0;
        in_valid = 1'b0;
        chk("t3_valid_after_clear", out_valid, 0);
        chk("t3_sum_after_clear", out_sum, 0);
        push(1); push(1); push(1);
        chk("t3_no_early_valid", out_valid, 0);
        push(1);
        chk("t3_valid", out_valid, 1);
        chk("t3_sum", out_sum, 4);
        tick();

        // 3b: clear in DONE discards the pending result
        out_ready = 1'b0;
        push(9); push(9); push(9); push(9);
        chk("t3b_pending", out_valid, 1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("t3b_discarded", out_valid, 0);
        chk("t3b_in_ready", in_ready, 1);
        out_ready = 1'b1;

        // 4: overflow at ACC_W=9
`ifdef PRODUCT_ACCUMULATOR_SAT_EN
        exp9_sum = 511;
        exp9_ovf = 1;
`else
        exp9_sum = 388;
        exp9_ovf = 0;
`endif
        out_ready9 = 1'b0;
        push9(225); push9(225); push9(225); push9(225);
        chk("t4_valid", out_valid9, 1);
        chk("t4_sum", out_sum9, exp9_sum);
        chk("t4_ovf", out_ovf9, exp9_ovf);
        out_ready9 = 1'b1;
        tick();
        chk("t4_ovf_cleared", out_ovf9, 0);
        push9(1); push9(1); push9(1); push9(1);
        chk("t4_next_sum", out_sum9, 4);
        chk("t4_next_ovf", out_ovf9, 0);
        tick();

        // 5: reset mid-accumulation
        push(7); push(7);
        rst_n = 1'b0;
        tick();
        chk("t5_valid_in_reset", out_valid, 0);
        chk("t5_sum_in_reset", out_sum, 0);
        rst_n = 1'b1;
        push(3); push(3); push(3);
        chk("t5_no_early_valid", out_valid, 0);
        push(3);
        chk("t5_valid", out_valid, 1);
        chk("t5_sum", out_sum, 12);
        tick();

        // 6: COUNT=1
        out_ready1 = 1'b0;
        in_valid1 = 1'b1;
        in_product1 = 42;
        tick();
        in_valid1 = 1'b0;
        chk("t6_valid", out_valid1, 1);
        chk("t6_sum", out_sum1, 42);
        out_ready1 = 1'b1;
        tick();
        chk("t6_valid_drop", out_valid1, 0);
        for (int r = 0; r < 20; r++) begin
            gap = $urandom_range(0, 3);
            out_ready1 = 1'b0;
            for (int g = 0; g < gap; g++) begin
                in_product1 = 8'($urandom_range(0, 255));
                tick();
            end
            p = 8'($urandom_range(0, 225));
            in_valid1 = 1'b1;
            in_product1 = p;
            tick();
            in_valid1 = 1'b0;
            in_product1 = 8'($urandom_range(0, 255));
            hold = $urandom_range(0, 2);
            for (int h = 0; h < hold; h++) begin
                tick();
            end
            chk("t6_rand_valid", out_valid1, 1);
            chk("t6_rand_sum", out_sum1, 32'(p));
            out_ready1 = 1'b1;
            tick();
            chk("t6_rand_drop", out_valid1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
